matrix_pe_core: RTL and testbench

- Int16 vector dot-product engine (matrix PE) between the instruction buffer (ib_ctl), neuron RAM (nram) and weight RAM (wram).
- Each accepted micro-op gives a count N of 512-bit neuron/weight line pairs.
- For each pair, the block multiplies 32 signed int16 lanes and sums them. It accumulates over N pairs and emits one 32-bit result with a single-cycle valid pulse.

---
 rtl/matrix_pe_core.sv | 210 +++++++++++++++++++++
 tb/tb_matrix_pe_core.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_pe_core.sv
// -----------------------------------------------------------------------------
// matrix_pe_core
//   Int16 vector dot-product engine. Each accepted micro-op carries a count N of
//   512-bit neuron/weight line pairs. Every pair contributes the sum of the
//   32 signed int16 lane products to a 32-bit accumulator. After N pairs the
//   accumulated value is presented on result with a one-cycle vld_o pulse.
//   All arithmetic wraps modulo 2^ACC_W.
//
// Optional feature macro: MATRIX_PE_MUL_PIPE_EN
//   Defined   : lane products are registered before the adder tree. Each pair
//               is accumulated one cycle after its handshake, so vld_o follows
//               the last pair handshake by 2 cycles.
//   Undefined : multiply and adder tree feed the accumulator combinationally,
//               so vld_o follows the last pair handshake by 1 cycle.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   nram_mpe_neuron[_valid/_ready]  neuron line stream (lane i = [16i+15:16i])
//   wram_mpe_weight[_valid/_ready]  weight line stream, same lane layout
//   ib_ctl_uop[_valid/_ready]       micro-op: unsigned pair count N
//   result                          accumulated dot product (two's complement)
//   vld_o                           one-cycle pulse, result valid
// -----------------------------------------------------------------------------
module matrix_pe_core #(
  parameter int LANES  = 32,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int UOP_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LANES*DATA_W-1:0]   nram_mpe_neuron,
  input  logic                      nram_mpe_neuron_valid,
  output logic                      nram_mpe_neuron_ready,
  input  logic [LANES*DATA_W-1:0]   wram_mpe_weight,
  input  logic                      wram_mpe_weight_valid,
  output logic                      wram_mpe_weight_ready,
  input  logic [UOP_W-1:0]          ib_ctl_uop,
  input  logic                      ib_ctl_uop_valid,
  output logic                      ib_ctl_uop_ready,
  output logic [ACC_W-1:0]          result,
  output logic                      vld_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [UOP_W-1:0]   count_r, count_s;
  logic [ACC_W-1:0]   acc_r, acc_s;
  logic [ACC_W-1:0]   result_r;
  logic               vld_r;
  logic               done_s;
  logic               pair_en_s;
  logic               pair_fire_s;
  logic               uop_fire_s;
  logic [ACC_W-1:0]   sum_s;

  // Signed lane product, sign-extended to the accumulator width; the low
  // ACC_W bits of the unsigned product equal the signed product.
  function automatic logic [ACC_W-1:0] lane_mul(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [ACC_W-1:0] ax;
    logic [ACC_W-1:0] bx;
    ax = {{(ACC_W-DATA_W){a[DATA_W-1]}}, a};
    bx = {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
    return ax * bx;
  endfunction

  // Pairs are only accepted while BUSY with pairs still outstanding; in the
  // pipelined build count_r reaches 0 one cycle before the last product drains.
  assign pair_en_s   = (state_r == ST_BUSY) && (count_r != '0);
  // Lockstep pairing: each stream is ready only when the other one is valid.
  assign nram_mpe_neuron_ready = pair_en_s && wram_mpe_weight_valid;
  assign wram_mpe_weight_ready = pair_en_s && nram_mpe_neuron_valid;
  assign pair_fire_s = pair_en_s && nram_mpe_neuron_valid && wram_mpe_weight_valid;
  // rst_n keeps uop_ready low while reset is asserted.
  assign ib_ctl_uop_ready = (state_r == ST_IDLE) && rst_n;
  assign uop_fire_s  = ib_ctl_uop_ready && ib_ctl_uop_valid;

`ifdef MATRIX_PE_MUL_PIPE_EN
  logic [ACC_W-1:0] prod_r [LANES];
  logic             prod_vld_r;

  // Product register stage: captures the lane products of a firing pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_vld_r <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        prod_r[i] <= '0;
      end
    end else begin
      prod_vld_r <= pair_fire_s;
      if (pair_fire_s) begin
        for (int i = 0; i < LANES; i++) begin
          prod_r[i] <= lane_mul(nram_mpe_neuron[i*DATA_W +: DATA_W],
                                wram_mpe_weight[i*DATA_W +: DATA_W]);
        end
      end
    end
  end

  // Adder tree over the registered products.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_s = sum_s + prod_r[i];
    end
  end
`else
  // Combinational multiply and adder tree over the current line pair.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_s = sum_s + lane_mul(nram_mpe_neuron[i*DATA_W +: DATA_W],
                               wram_mpe_weight[i*DATA_W +: DATA_W]);
    end
  end
`endif

  // Next-state, count and accumulator logic.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    acc_s   = acc_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (uop_fire_s) begin
          acc_s = '0;
          if (ib_ctl_uop == '0) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            count_s = ib_ctl_uop;
            state_s = ST_BUSY;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
`ifdef MATRIX_PE_MUL_PIPE_EN
        if (prod_vld_r) begin
          acc_s = acc_r + sum_s;
        end else begin
          acc_s = acc_r;
        end
        if (pair_fire_s) begin
          count_s = count_r - UOP_W'(1);
        end else begin
          count_s = count_r;
        end
        // count_r is zero with a product pending only for the final pair.
        if ((count_r == '0) && prod_vld_r) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_BUSY;
        end
`else
        if (pair_fire_s) begin
          acc_s   = acc_r + sum_s;
          count_s = count_r - UOP_W'(1);
          if (count_r == UOP_W'(1)) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_BUSY;
          end
        end else begin
          state_s = ST_BUSY;
        end
`endif
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, accumulator and registered outputs; result is written on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      count_r  <= '0;
      acc_r    <= '0;
      result_r <= '0;
      vld_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      acc_r   <= acc_s;
      vld_r   <= done_s;
      if (done_s) begin
        result_r <= acc_s;
      end
    end
  end

  assign result = result_r;
  assign vld_o  = vld_r;

endmodule

// File: tb/tb_matrix_pe_core.sv
// -----------------------------------------------------------------------------
// tb_matrix_pe_core
//   Directed self-checking bench for matrix_pe_core. Inputs are driven 1 ns
//   after the rising edge; handshakes and vld_o are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_matrix_pe_core;
  localparam int LW = 512;
`ifdef MATRIX_PE_MUL_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] neuron = '0;
  logic          nv = 1'b0;
  logic          nr;
  logic [LW-1:0] weight = '0;
  logic          wv = 1'b0;
  logic          wr;
  logic [7:0]    uop = 8'd0;
  logic          uv = 1'b0;
  logic          ur;
  logic [31:0]   result;
  logic          vld_o;

  always #5 clk = ~clk;

  matrix_pe_core dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .nram_mpe_neuron       (neuron),
    .nram_mpe_neuron_valid (nv),
    .nram_mpe_neuron_ready (nr),
    .wram_mpe_weight       (weight),
    .wram_mpe_weight_valid (wv),
    .wram_mpe_weight_ready (wr),
    .ib_ctl_uop            (uop),
    .ib_ctl_uop_valid      (uv),
    .ib_ctl_uop_ready      (ur),
    .result                (result),
    .vld_o                 (vld_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Handshake / pulse monitor
  int cyc = 0;
  int nh = 0, wh = 0, uh = 0, vcnt = 0, dbl = 0;
  int hs_cyc = 0, uop_cyc = 0, vld_cyc = 0;
  logic prev_vld = 1'b0;
  logic [31:0] vres = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nv && nr) begin
      nh <= nh + 1;
      hs_cyc <= cyc;
    end
    if (wv && wr) wh <= wh + 1;
    if (uv && ur) begin
      uh <= uh + 1;
      uop_cyc <= cyc;
    end
    if (vld_o) begin
      vcnt <= vcnt + 1;
      vld_cyc <= cyc;
      vres <= result;
      if (prev_vld) dbl <= dbl + 1;
    end
    prev_vld <= vld_o;
  end

  logic [LW-1:0] nl [0:255];
  logic [LW-1:0] wl [0:255];

  function automatic int dot(input logic [LW-1:0] a, input logic [LW-1:0] b);
    int s;
    logic signed [15:0] x, y;
    s = 0;
    for (int i = 0; i < 32; i++) begin
      x = a[16*i +: 16];
      y = b[16*i +: 16];
      s += int'(x) * int'(y);
    end
    return s;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [LW-1:0] fill(input logic [15:0] v);
    logic [LW-1:0] l;
    for (int i = 0; i < 32; i++) l[16*i +: 16] = v;
    return l;
  endfunction

  task automatic run_uop(input int n, input bit rnd, input string tag);
    int nb, wb, ub, vb, k, got;
    logic [31:0] expv;
    expv = 32'd0;
    for (int j = 0; j < n; j++) expv += dot(nl[j], wl[j]);
    nb = nh; wb = wh; ub = uh; vb = vcnt; got = 0;
    for (int c = 0; c < 3000 && got == 0; c++) begin
      @(posedge clk); #1;
      if (vcnt != vb) begin
        got = 1;
      end else begin
        k = nh - nb;
        neuron = (k < n) ? nl[k] : rnd_line();
        weight = (k < n) ? wl[k] : rnd_line();
        nv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        wv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (uh == ub) begin
          uop = 8'(n);
          uv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end else begin
          uop = 8'($urandom);
          uv = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
    end
    nv = 1'b0; wv = 1'b0; uv = 1'b0;
    chk({tag, "/done"}, 32'(got), 32'd1);
    chk({tag, "/result"}, vres, expv);
    chk({tag, "/n_hs"}, 32'(nh - nb), 32'(n));
    chk({tag, "/w_hs"}, 32'(wh - wb), 32'(n));
    chk({tag, "/uop_hs"}, 32'(uh - ub), 32'd1);
    chk({tag, "/pulses"}, 32'(vcnt - vb), 32'd1);
    if (n > 0) chk({tag, "/latency"}, 32'(vld_cyc - hs_cyc), 32'(LAT));
    else       chk({tag, "/latency"}, 32'(vld_cyc - uop_cyc), 32'd1);
  endtask

  initial begin
    int nb, ub, vb, k;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst/uop_ready", 32'(ur), 32'd0);
    chk("rst/vld", 32'(vld_o), 32'd0);
    chk("rst/result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle/uop_ready", 32'(ur), 32'd1);
    chk("idle/n_ready", 32'(nr), 32'd0);

    // All ones
    nl[0] = fill(16'h0001); wl[0] = fill(16'h0001);
    run_uop(1, 1'b0, "ones");
    chk("ones/const", vres, 32'h00000020);

    // Negative lanes
    nl[0] = fill(16'hFFFF); wl[0] = fill(16'h0002);
    run_uop(1, 1'b0, "neg");
    chk("neg/const", vres, 32'hFFFFFFC0);

    // Wrapping maximum
    nl[0] = fill(16'h7FFF); wl[0] = fill(16'h7FFF);
    run_uop(1, 1'b0, "wrap");
    chk("wrap/const", vres, 32'hFFE00020);

    // N=3 with random valids
    for (int j = 0; j < 3; j++) begin
      nl[j] = fill(16'(j + 1));
      wl[j] = fill(16'h0001);
    end
    run_uop(3, 1'b1, "rnd3");
    chk("rnd3/const", vres, 32'd192);
    repeat (3) @(posedge clk);
    #1;
    chk("hold/result", result, 32'd192);
    chk("hold/vld", 32'(vld_o), 32'd0);

    // N=0
    run_uop(0, 1'b0, "zero");
    chk("zero/result", result, 32'd0);
    chk("zero/uop_ready", 32'(ur), 32'd1);

    // Four uops of N=35 with random data and valids
    for (int u = 0; u < 4; u++) begin
      for (int j = 0; j < 35; j++) begin
        nl[j] = rnd_line();
        wl[j] = rnd_line();
      end
      run_uop(35, 1'b1, $sformatf("rand%0d", u));
    end

    // Fifth uop aborted by reset
    for (int j = 0; j < 35; j++) begin
      nl[j] = rnd_line();
      wl[j] = rnd_line();
    end
    nb = nh; ub = uh; vb = vcnt;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      k = nh - nb;
      neuron = nl[k];
      weight = wl[k];
      nv = 1'($urandom_range(0, 1));
      wv = 1'($urandom_range(0, 1));
      uop = 8'd35;
      uv = (uh == ub) ? 1'b1 : 1'b0;
    end
    chk("abort/uop_hs", 32'(uh - ub), 32'd1);
    rst_n = 1'b0;
    nv = 1'b0; wv = 1'b0; uv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort/result", result, 32'd0);
    chk("abort/vld", 32'(vld_o), 32'd0);
    chk("abort/uop_ready_rst", 32'(ur), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort/uop_ready", 32'(ur), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("abort/no_pulse", 32'(vcnt - vb), 32'd0);
    chk("abort/result_after", result, 32'd0);
    chk("abort/idle_ready", 32'(ur), 32'd1);

    chk("vld_double", 32'(dbl), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
